// File: rtl/unidade_controle_jogada_if.sv
// Control bundle between the move-sequencing FSM (master) and the switch/memory datapath (slave).
interface unidade_controle_jogada_if;
    logic       iniciar;
    logic       jogada_nivel;
    logic       igual;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada_nivel, igual, fimC,
        output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, jogada_nivel, igual, fimC,
        input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogada.sv
// Moore controller for the switch/memory comparison round: waits for each move,
// registers and compares it, advances on a hit, ends on hit-all, miss or move timeout.
//
// state      | meaning
// INICIAL    | idle after reset, waiting for iniciar
// PREPARA    | clear address counter and switch register
// ESPERA     | waiting for a move edge, timeout counter running
// REGISTRA   | load the switch register
// COMPARA    | evaluate igual / fimC
// PROXIMO    | advance the address counter
// FIM_ACERTO | round won
// FIM_ERRO   | round lost on a miss
// FIM_TMO    | round lost on a move timeout
module unidade_controle_jogada #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TMR_W          = 13
) (
    input  logic                          clock,
    input  logic                          reset,
    unidade_controle_jogada_if.master     bus
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARA    = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h4,
        COMPARA    = 4'h5,
        PROXIMO    = 4'h6,
        FIM_ACERTO = 4'hA,
        FIM_TMO    = 4'hD,
        FIM_ERRO   = 4'hE
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [TMR_W-1:0] tmr;
    logic             jog_q;
    logic             jogada;

    logic       zera_c, conta_c, zera_r, registra_r;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    assign jogada = bus.jogada_nivel & ~jog_q;

    always_comb begin
        state_n = INICIAL;
        case (state)
            INICIAL:  state_n = bus.iniciar ? PREPARA : INICIAL;
            PREPARA:  state_n = ESPERA;
            ESPERA: begin
                // A move arriving on the last allowed clock still counts.
                if (jogada)
                    state_n = REGISTRA;
                else if (tmr == TMR_LAST)
                    state_n = FIM_TMO;
                else
                    state_n = ESPERA;
            end
            REGISTRA: state_n = COMPARA;
            COMPARA: begin
                if (!bus.igual)
                    state_n = FIM_ERRO;
                else if (bus.fimC)
                    state_n = FIM_ACERTO;
                else
                    state_n = PROXIMO;
            end
            PROXIMO:    state_n = ESPERA;
            FIM_ACERTO: state_n = bus.iniciar ? PREPARA : FIM_ACERTO;
            FIM_ERRO:   state_n = bus.iniciar ? PREPARA : FIM_ERRO;
            FIM_TMO:    state_n = bus.iniciar ? PREPARA : FIM_TMO;
            default:    state_n = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= INICIAL;
            tmr         <= '0;
            jog_q       <= 1'b0;
            zera_c      <= 1'b0;
            conta_c     <= 1'b0;
            zera_r      <= 1'b0;
            registra_r  <= 1'b0;
            pronto      <= 1'b0;
            acertou     <= 1'b0;
            errou       <= 1'b0;
            timeout     <= 1'b0;
            db_estado   <= 4'h0;
        end else begin
            state <= state_n;
            jog_q <= bus.jogada_nivel;
            if (state == ESPERA)
                tmr <= (tmr == TMR_LAST) ? tmr : tmr + TMR_W'(1);
            else
                tmr <= '0;
            zera_c     <= (state_n == PREPARA);
            zera_r     <= (state_n == PREPARA);
            conta_c    <= (state_n == PROXIMO);
            registra_r <= (state_n == REGISTRA);
            pronto     <= (state_n == FIM_ACERTO) || (state_n == FIM_ERRO) || (state_n == FIM_TMO);
            acertou    <= (state_n == FIM_ACERTO);
            errou      <= (state_n == FIM_ERRO) || (state_n == FIM_TMO);
            timeout    <= (state_n == FIM_TMO);
            db_estado  <= state_n;
        end
    end

    assign bus.zeraC     = zera_c;
    assign bus.contaC    = conta_c;
    assign bus.zeraR     = zera_r;
    assign bus.registraR = registra_r;
    assign bus.pronto    = pronto;
    assign bus.acertou   = acertou;
    assign bus.errou     = errou;
    assign bus.timeout   = timeout;
    assign bus.db_estado = db_estado;

endmodule

// File: tb/tb_unidade_controle_jogada.sv
// Directed vector bench for unidade_controle_jogada with TIMEOUT_CYCLES=8.
module tb_unidade_controle_jogada;

    localparam int T = 8;

    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_PREP  = 8'b1010_0000;
    localparam logic [7:0] O_CONTA = 8'b0100_0000;
    localparam logic [7:0] O_REG   = 8'b0001_0000;
    localparam logic [7:0] O_ACE   = 8'b0000_1100;
    localparam logic [7:0] O_ERR   = 8'b0000_1010;
    localparam logic [7:0] O_TMO   = 8'b0000_1011;

    typedef struct {
        logic       rst;
        logic       ini;
        logic       jn;
        logic       ig;
        logic       fc;
        logic [3:0] st;
        logic [7:0] o;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    unidade_controle_jogada_if bus ();

    unidade_controle_jogada #(.TIMEOUT_CYCLES(T), .TMR_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] outs();
        return {bus.zeraC, bus.contaC, bus.zeraR, bus.registraR,
                bus.pronto, bus.acertou, bus.errou, bus.timeout};
    endfunction

    task automatic drive(input logic r, input logic i, input logic j, input logic g, input logic f);
        reset            = r;
        bus.iniciar      = i;
        bus.jogada_nivel = j;
        bus.igual        = g;
        bus.fimC         = f;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] st, input logic [7:0] o);
        n_cmp++;
        if (bus.db_estado !== st || outs() !== o) begin
            n_bad++;
            $display("FAIL %s: got estado=%h outs=%b, want estado=%h outs=%b",
                     name, bus.db_estado, outs(), st, o);
        end
    endtask

    task automatic add(input logic r, input logic i, input logic j, input logic g,
                       input logic f, input logic [3:0] st, input logic [7:0] o);
        vec_t v;
        v.rst = r; v.ini = i; v.jn = j; v.ig = g; v.fc = f; v.st = st; v.o = o;
        vecs.push_back(v);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);

        // rst ini jn ig fc  state  outs
        add(1, 0, 0, 0, 0, 4'h0, O_NONE);
        add(0, 0, 0, 0, 0, 4'h0, O_NONE);
        add(0, 1, 0, 0, 0, 4'h1, O_PREP);
        add(0, 0, 0, 0, 0, 4'h2, O_NONE);
        // four hits, fimC on the last
        add(0, 0, 1, 0, 0, 4'h4, O_REG);
        add(0, 0, 0, 1, 0, 4'h5, O_NONE);
        add(0, 0, 0, 1, 0, 4'h6, O_CONTA);
        add(0, 0, 0, 1, 0, 4'h2, O_NONE);
        add(0, 0, 1, 1, 0, 4'h4, O_REG);
        add(0, 1, 0, 1, 0, 4'h5, O_NONE);
        add(0, 1, 0, 1, 0, 4'h6, O_CONTA);
        add(0, 0, 0, 1, 0, 4'h2, O_NONE);
        add(0, 0, 1, 1, 0, 4'h4, O_REG);
        add(0, 0, 0, 1, 0, 4'h5, O_NONE);
        add(0, 0, 0, 1, 0, 4'h6, O_CONTA);
        add(0, 0, 0, 1, 0, 4'h2, O_NONE);
        add(0, 0, 1, 1, 0, 4'h4, O_REG);
        add(0, 0, 0, 1, 1, 4'h5, O_NONE);
        add(0, 0, 0, 1, 1, 4'hA, O_ACE);
        add(0, 0, 0, 0, 0, 4'hA, O_ACE);
        // restart, miss on move 2
        add(0, 1, 0, 0, 0, 4'h1, O_PREP);
        add(0, 0, 0, 0, 0, 4'h2, O_NONE);
        add(0, 0, 1, 0, 0, 4'h4, O_REG);
        add(0, 0, 0, 1, 0, 4'h5, O_NONE);
        add(0, 0, 0, 1, 0, 4'h6, O_CONTA);
        add(0, 0, 0, 1, 0, 4'h2, O_NONE);
        add(0, 0, 1, 0, 0, 4'h4, O_REG);
        add(0, 0, 0, 0, 0, 4'h5, O_NONE);
        add(0, 0, 0, 0, 0, 4'hE, O_ERR);
        add(0, 0, 0, 0, 0, 4'hE, O_ERR);
        add(0, 1, 0, 0, 0, 4'h1, O_PREP);
        add(0, 0, 0, 0, 0, 4'h2, O_NONE);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].ini, vecs[k].jn, vecs[k].ig, vecs[k].fc);
            step();
            check($sformatf("vec%0d", k), vecs[k].st, vecs[k].o);
        end

        // Timeout: 7 more clocks in ESPERA stay, the 8th ends the round.
        for (int k = 1; k < T; k++) begin
            step();
            check($sformatf("tmo_wait%0d", k), 4'h2, O_NONE);
        end
        n_cmp++;
        if (dut.tmr !== 4'd7) begin
            n_bad++;
            $display("FAIL tmr_before_tmo: got %0d, want 7", dut.tmr);
        end
        step();
        check("tmo_fire", 4'hD, O_TMO);
        step();
        check("tmo_hold", 4'hD, O_TMO);

        // Move on the 8th clock wins over the timeout.
        drive(0, 1, 0, 0, 0); step(); check("re_prep", 4'h1, O_PREP);
        drive(0, 0, 0, 0, 0); step(); check("re_espera", 4'h2, O_NONE);
        for (int k = 1; k < T; k++) step();
        check("late_wait", 4'h2, O_NONE);
        drive(0, 0, 1, 0, 0); step(); check("late_move", 4'h4, O_REG);
        drive(0, 0, 0, 0, 0); step(); check("late_cmp", 4'h5, O_NONE);
        step(); check("late_err", 4'hE, O_ERR);

        // Switches held across PROXIMO -> ESPERA must not re-trigger.
        drive(0, 1, 0, 0, 0); step(); check("hold_prep", 4'h1, O_PREP);
        drive(0, 0, 0, 0, 0); step(); check("hold_espera", 4'h2, O_NONE);
        drive(0, 0, 1, 1, 0); step(); check("hold_reg", 4'h4, O_REG);
        step(); check("hold_cmp", 4'h5, O_NONE);
        step(); check("hold_prox", 4'h6, O_CONTA);
        step(); check("hold_back", 4'h2, O_NONE);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("hold_idle%0d", k), 4'h2, O_NONE);
        end
        drive(0, 0, 0, 1, 0); step(); check("hold_release", 4'h2, O_NONE);
        // tmr is at T-1 here: the new press and the timeout coincide.
        drive(0, 0, 1, 1, 0); step(); check("hold_repress", 4'h4, O_REG);
        drive(0, 0, 0, 1, 0); step(); check("pre_rst_cmp", 4'h5, O_NONE);

        // Reset while in COMPARA.
        drive(1, 1, 1, 1, 1); step(); check("mid_reset", 4'h0, O_NONE);
        n_cmp++;
        if (dut.tmr !== 4'd0) begin
            n_bad++;
            $display("FAIL tmr_after_reset: got %0d, want 0", dut.tmr);
        end
        drive(0, 0, 0, 0, 0); step(); check("post_reset", 4'h0, O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
